// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter
//   Two-requester round-robin arbiter and sequencer in front of a 32x8
//   register file (two registered read ports, one write port). A granted
//   transaction bundle is driven onto the register file for one cycle, the
//   read data is captured and returned with a one-cycle response strobe.
//   A bundle that reads the address it also writes is split into a write
//   cycle followed by a read cycle, so the read returns the new value.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   a_* / b_*                  requester bundles: req/op/addresses/wdata in,
//                              ack, rsp_valid and rdata1/rdata2 out
//   rf_read1/2, rf_write,
//   rf_write_data,
//   rf_input_valid             register-file controls (registered)
//   rf_out1, rf_out2           register-file read data
//   busy                       high whenever the sequencer is not idle
module reg_file_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [2:0]        a_op,
  input  logic [ADDR_W-1:0] a_read1,
  input  logic [ADDR_W-1:0] a_read2,
  input  logic [ADDR_W-1:0] a_write,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rdata1,
  output logic [DATA_W-1:0] a_rdata2,
  input  logic              b_req,
  input  logic [2:0]        b_op,
  input  logic [ADDR_W-1:0] b_read1,
  input  logic [ADDR_W-1:0] b_read2,
  input  logic [ADDR_W-1:0] b_write,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rdata1,
  output logic [DATA_W-1:0] b_rdata2,
  output logic [ADDR_W-1:0] rf_read1,
  output logic [ADDR_W-1:0] rf_read2,
  output logic [ADDR_W-1:0] rf_write,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [2:0]        rf_input_valid,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WR_FIRST  = 3'd2,
    RD_SECOND = 3'd3,
    CAPTURE   = 3'd4
  } state_t;

  state_t      state_r;
  logic        last_grant_r;  // 1'b0 = A, 1'b1 = B
  logic        grant_r;       // owner of the transaction in flight
  logic [1:0]  rd_op_r;       // {read port 1, read port 2} of the latched op

  logic              grant_b_s;
  logic [2:0]        sel_op_s;
  logic [ADDR_W-1:0] sel_read1_s;
  logic [ADDR_W-1:0] sel_read2_s;
  logic [ADDR_W-1:0] sel_write_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              split_s;

  // Arbitration and bundle selection for the IDLE grant decision.
  always_comb begin
    grant_b_s = 1'b0;
    if (a_req && b_req) begin
      // Contention: the requester not served last time wins.
      grant_b_s = (last_grant_r == 1'b0);
    end else if (b_req) begin
      grant_b_s = 1'b1;
    end else begin
      grant_b_s = 1'b0;
    end

    if (grant_b_s) begin
      sel_op_s    = b_op;
      sel_read1_s = b_read1;
      sel_read2_s = b_read2;
      sel_write_s = b_write;
      sel_wdata_s = b_wdata;
    end else begin
      sel_op_s    = a_op;
      sel_read1_s = a_read1;
      sel_read2_s = a_read2;
      sel_write_s = a_write;
      sel_wdata_s = a_wdata;
    end

    // A read hitting the written address must observe the new data.
    split_s = sel_op_s[0] &&
              ((sel_op_s[2] && (sel_read1_s == sel_write_s)) ||
               (sel_op_s[1] && (sel_read2_s == sel_write_s)));
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      last_grant_r   <= 1'b1;
      grant_r        <= 1'b0;
      rd_op_r        <= 2'b00;
      a_ack          <= 1'b0;
      b_ack          <= 1'b0;
      a_rsp_valid    <= 1'b0;
      b_rsp_valid    <= 1'b0;
      a_rdata1       <= {DATA_W{1'b0}};
      a_rdata2       <= {DATA_W{1'b0}};
      b_rdata1       <= {DATA_W{1'b0}};
      b_rdata2       <= {DATA_W{1'b0}};
      rf_read1       <= {ADDR_W{1'b0}};
      rf_read2       <= {ADDR_W{1'b0}};
      rf_write       <= {ADDR_W{1'b0}};
      rf_write_data  <= {DATA_W{1'b0}};
      rf_input_valid <= 3'b000;
      busy           <= 1'b0;
    end else begin
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (a_req || b_req) begin
            grant_r       <= grant_b_s;
            last_grant_r  <= grant_b_s;
            a_ack         <= ~grant_b_s;
            b_ack         <= grant_b_s;
            rd_op_r       <= sel_op_s[2:1];
            rf_read1      <= sel_read1_s;
            rf_read2      <= sel_read2_s;
            rf_write      <= sel_write_s;
            rf_write_data <= sel_wdata_s;
            busy          <= 1'b1;
            if (split_s) begin
              state_r        <= WR_FIRST;
              rf_input_valid <= 3'b001;
            end else begin
              state_r        <= ISSUE;
              rf_input_valid <= sel_op_s;
            end
          end else begin
            state_r        <= IDLE;
            rf_input_valid <= 3'b000;
            busy           <= 1'b0;
          end
        end
        ISSUE: begin
          rf_input_valid <= 3'b000;
          state_r        <= CAPTURE;
        end
        WR_FIRST: begin
          rf_input_valid <= {rd_op_r[1], rd_op_r[0], 1'b0};
          state_r        <= RD_SECOND;
        end
        RD_SECOND: begin
          rf_input_valid <= 3'b000;
          state_r        <= CAPTURE;
        end
        CAPTURE: begin
          // Only requested read ports update the requester's rdata.
          if (grant_r) begin
            if (rd_op_r[1]) b_rdata1 <= rf_out1;
            if (rd_op_r[0]) b_rdata2 <= rf_out2;
            b_rsp_valid <= 1'b1;
          end else begin
            if (rd_op_r[1]) a_rdata1 <= rf_out1;
            if (rd_op_r[0]) a_rdata2 <= rf_out2;
            a_rsp_valid <= 1'b1;
          end
          rf_input_valid <= 3'b000;
          state_r        <= IDLE;
          busy           <= 1'b0;
        end
        default: begin
          rf_input_valid <= 3'b000;
          state_r        <= IDLE;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule
